// File: rtl/change_payout_if.sv
// change_payout_if: groups the vending-side request, hopper handshake and
// status signals of change_payout.
//   master : the driving side (vending fsm / hopper model). It drives d, r and
//            hopper_rdy, and observes the outputs.
//   slave  : change_payout itself.
// Signals:
//   d          dispense request (level)
//   r[CW-1:0]  change owed, in units
//   hopper_rdy hopper accepts the presented coin this cycle
//   motor      product motor enable
//   pay_two    valid, one 2-unit coin
//   pay_one    valid, one 1-unit coin
//   busy, done, ovr : status
//   coin_total : units paid, present only when PAYOUT_COUNT_EN is defined
interface change_payout_if #(
    parameter int CW = 3
);
    logic          d;
    logic [CW-1:0] r;
    logic          hopper_rdy;
    logic          motor;
    logic          pay_two;
    logic          pay_one;
    logic          busy;
    logic          done;
    logic          ovr;
`ifdef PAYOUT_COUNT_EN
    logic [7:0]    coin_total;

    modport master (
        output d, r, hopper_rdy,
        input  motor, pay_two, pay_one, busy, done, ovr, coin_total
    );
    modport slave (
        input  d, r, hopper_rdy,
        output motor, pay_two, pay_one, busy, done, ovr, coin_total
    );
`else
    modport master (
        output d, r, hopper_rdy,
        input  motor, pay_two, pay_one, busy, done, ovr
    );
    modport slave (
        input  d, r, hopper_rdy,
        output motor, pay_two, pay_one, busy, done, ovr
    );
`endif
endinterface

// File: rtl/change_payout.sv
// change_payout: takes the dispense strobe and change code from the vending
// fsm. It runs the product motor for VEND_CYCLES cycles, then pays the change
// greedily to the coin hopper: all 2-unit coins first, then at most one
// 1-unit coin. Each coin uses a valid/ready handshake.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   bus    change_payout_if.slave
//          inputs : d, r, hopper_rdy
//          outputs: motor, pay_two, pay_one, busy, done, ovr [, coin_total]
// Optional feature: define PAYOUT_COUNT_EN to add the saturating coin_total
// counter, which counts units paid.
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | waiting for d
// S_VEND | motor on, cnt counts VEND_CYCLES down to 0
// S_PAY  | presenting one coin, waiting for hopper_rdy
// S_GAP  | idle spacing after an accepted coin, COIN_GAP cycles
// S_DONE | one-cycle done pulse, then back to idle
module change_payout #(
    parameter int VEND_CYCLES = 4,
    parameter int COIN_GAP    = 2,
    parameter int CW          = 3
) (
    input  logic           clk,
    input  logic           reset,
    change_payout_if.slave bus
);

    localparam int CMAX = (VEND_CYCLES > COIN_GAP) ? VEND_CYCLES : COIN_GAP;
    localparam int CNTW = (CMAX < 2) ? 1 : $clog2(CMAX);
    localparam logic [CNTW-1:0] VEND_LOAD = CNTW'(VEND_CYCLES - 1);
    localparam logic [CNTW-1:0] GAP_LOAD  = (COIN_GAP > 0) ? CNTW'(COIN_GAP - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEND,
        S_PAY,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] chg_q, chg_d;
    logic          ovr_q, ovr_d;
    logic          motor_q, motor_d;
    logic          pay_two_q, pay_two_d;
    logic          pay_one_q, pay_one_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          xfer;
    logic          xfer_two;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        chg_d    = chg_q;
        xfer     = 1'b0;
        xfer_two = (chg_q >= CW'(2));
        // A request that arrives while a vend is in progress is never queued.
        // It is only flagged.
        ovr_d    = ovr_q | (bus.d && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (bus.d) begin
                    chg_d   = bus.r;
                    cnt_d   = VEND_LOAD;
                    state_d = S_VEND;
                end
            end
            S_VEND: begin
                if (cnt_q == '0) begin
                    state_d = (chg_q != '0) ? S_PAY : S_DONE;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            S_PAY: begin
                if (bus.hopper_rdy) begin
                    xfer  = 1'b1;
                    chg_d = xfer_two ? (chg_q - CW'(2)) : (chg_q - CW'(1));
                    if (COIN_GAP > 0) begin
                        cnt_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        state_d = (chg_d != '0) ? S_PAY : S_DONE;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = (chg_q != '0) ? S_PAY : S_DONE;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered. They are decoded from the next state so that
        // each output changes on the same edge as the state it belongs to.
        motor_d   = (state_d == S_VEND);
        pay_two_d = (state_d == S_PAY) && (chg_d >= CW'(2));
        pay_one_d = (state_d == S_PAY) && (chg_d == CW'(1));
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            chg_q     <= '0;
            ovr_q     <= 1'b0;
            motor_q   <= 1'b0;
            pay_two_q <= 1'b0;
            pay_one_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            chg_q     <= chg_d;
            ovr_q     <= ovr_d;
            motor_q   <= motor_d;
            pay_two_q <= pay_two_d;
            pay_one_q <= pay_one_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.motor   = motor_q;
    assign bus.pay_two = pay_two_q;
    assign bus.pay_one = pay_one_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ovr     = ovr_q;

`ifdef PAYOUT_COUNT_EN
    logic [7:0] coin_total_q, coin_total_d;
    logic [8:0] coin_sum;

    always_comb begin
        coin_sum     = {1'b0, coin_total_q} + (xfer_two ? 9'd2 : 9'd1);
        coin_total_d = coin_total_q;
        if (xfer) begin
            coin_total_d = coin_sum[8] ? 8'hFF : coin_sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            coin_total_q <= '0;
        end else begin
            coin_total_q <= coin_total_d;
        end
    end

    assign bus.coin_total = coin_total_q;
`endif

endmodule

// File: tb/tb_change_payout.sv
module tb_change_payout;

    localparam int VEND = 4;
    localparam int GAP  = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    change_payout_if #(.CW(3)) bus ();

    change_payout #(.VEND_CYCLES(VEND), .COIN_GAP(GAP), .CW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: the vend is a list of coins still owed and timers
    // for the motor and the gap.
    int  m_motor_left = 0;
    int  m_gap_left   = 0;
    int  m_coins[$];
    bit  m_done       = 1'b0;
    bit  m_ovr        = 1'b0;
    int  m_total      = 0;
    bit  m_active;

    always @(posedge clk) begin
        if (!reset) begin
            m_motor_left = 0;
            m_gap_left   = 0;
            m_coins.delete();
            m_done       = 1'b0;
            m_ovr        = 1'b0;
            m_total      = 0;
        end else begin
            m_active = (m_motor_left > 0) || (m_gap_left > 0) || (m_coins.size() > 0) || m_done;
            if (m_active && bus.d) m_ovr = 1'b1;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_motor_left > 0) begin
                m_motor_left--;
                if (m_motor_left == 0 && m_coins.size() == 0) m_done = 1'b1;
            end else if (m_gap_left > 0) begin
                m_gap_left--;
                if (m_gap_left == 0 && m_coins.size() == 0) m_done = 1'b1;
            end else if (m_coins.size() > 0) begin
                if (bus.hopper_rdy) begin
                    m_total = m_total + m_coins[0];
                    if (m_total > 255) m_total = 255;
                    void'(m_coins.pop_front());
                    if (GAP > 0) m_gap_left = GAP;
                    else if (m_coins.size() == 0) m_done = 1'b1;
                end
            end else if (bus.d) begin
                m_motor_left = VEND;
                for (int k = 0; k < int'(bus.r) / 2; k++) m_coins.push_back(2);
                if (bus.r[0]) m_coins.push_back(1);
            end
        end
    end

    // Compare process, plus counters of observed DUT activity.
    int  n_motor = 0;
    int  n_done  = 0;
    int  seq[$];
    bit  prev_two = 1'b0;
    bit  prev_one = 1'b0;
    bit  e_paying;
    logic [5:0] exp_v, got_v;

    always @(negedge clk) begin
        e_paying = (m_motor_left == 0) && (m_gap_left == 0) && (m_coins.size() > 0) && !m_done;
        exp_v = {m_motor_left > 0,
                 e_paying && m_coins.size() > 0 && m_coins[0] == 2,
                 e_paying && m_coins.size() > 0 && m_coins[0] == 1,
                 (m_motor_left > 0) || (m_gap_left > 0) || (m_coins.size() > 0) || m_done,
                 m_done, m_ovr};
        got_v = {bus.motor, bus.pay_two, bus.pay_one, bus.busy, bus.done, bus.ovr};
        chk("outputs{motor,two,one,busy,done,ovr}", int'(got_v), int'(exp_v));
`ifdef PAYOUT_COUNT_EN
        chk("coin_total", int'(bus.coin_total), m_total);
`endif
        // hopper_rdy and reset still hold the values that applied at the last edge.
        if (reset && bus.hopper_rdy && prev_two) seq.push_back(2);
        if (reset && bus.hopper_rdy && prev_one) seq.push_back(1);
        prev_two = bus.pay_two;
        prev_one = bus.pay_one;
        if (bus.motor) n_motor++;
        if (bus.done)  n_done++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic vend(input int val);
        step();
        bus.d = 1'b1;
        bus.r = 3'(val);
        step();
        bus.d = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 200) begin
            step();
            n++;
        end
        if (bus.busy) chk({name, "_idle_timeout"}, 1, 0);
    endtask

    task automatic wait_two(input string name);
        int n = 0;
        while (!bus.pay_two && n < 50) begin
            step();
            n++;
        end
        if (!bus.pay_two) chk({name, "_pay_two_timeout"}, 0, 1);
    endtask

    int s_motor, s_done, s_seq, held;

    initial begin
        reset = 1'b0;
        bus.d = 1'b1;
        bus.r = 3'd7;
        bus.hopper_rdy = 1'b1;

        // 1: reset holds off a pending request, and the vend starts right after release
        step(); step();
        chk("t1_busy_in_reset", int'(bus.busy), 0);
        chk("t1_motor_in_reset", int'(bus.motor), 0);
        reset = 1'b1;
        step();
        chk("t1_motor_after_release", int'(bus.motor), 1);
        bus.d = 1'b0;
        wait_idle("t1");
        step();

        // 2: r=0 gives motor for 4 cycles, no coins, and one done pulse
        s_motor = n_motor; s_done = n_done; s_seq = seq.size();
        vend(0);
        wait_idle("t2");
        chk("t2_motor_cycles", n_motor - s_motor, 4);
        chk("t2_done_pulses", n_done - s_done, 1);
        chk("t2_coins", seq.size() - s_seq, 0);

        // 3: r=5 pays two, two, one
        reset = 1'b0; step(); reset = 1'b1;
        s_seq = seq.size();
        vend(5);
        wait_idle("t3");
        chk("t3_coin_count", seq.size() - s_seq, 3);
        if (seq.size() - s_seq == 3) begin
            chk("t3_coin0", seq[s_seq], 2);
            chk("t3_coin1", seq[s_seq+1], 2);
            chk("t3_coin2", seq[s_seq+2], 1);
        end
`ifdef PAYOUT_COUNT_EN
        chk("t3_coin_total", int'(bus.coin_total), 5);
`endif

        // 4: r=3 with the hopper stalled, so pay_two is held for 6 cycles
        bus.hopper_rdy = 1'b0;
        s_seq = seq.size();
        vend(3);
        wait_two("t4");
        held = int'(bus.pay_two);
        repeat (5) begin
            step();
            held += int'(bus.pay_two);
        end
        chk("t4_two_held", held, 6);
        bus.hopper_rdy = 1'b1;
        wait_idle("t4");
        chk("t4_coin_count", seq.size() - s_seq, 2);
        if (seq.size() - s_seq == 2) begin
            chk("t4_coin0", seq[s_seq], 2);
            chk("t4_coin1", seq[s_seq+1], 1);
        end

        // 5: d raised during VEND sets sticky ovr and does not start a second vend
        s_motor = n_motor; s_done = n_done;
        vend(0);
        step();
        bus.d = 1'b1;
        step();
        bus.d = 1'b0;
        wait_idle("t5");
        step(); step();
        chk("t5_ovr_sticky", int'(bus.ovr), 1);
        chk("t5_done_pulses", n_done - s_done, 1);
        chk("t5_motor_cycles", n_motor - s_motor, 4);
        reset = 1'b0; step(); reset = 1'b1;
        chk("t5_ovr_cleared", int'(bus.ovr), 0);

        // 6: reset during PAY aborts; a new vend with r=1 pays one single coin
        bus.hopper_rdy = 1'b0;
        vend(6);
        wait_two("t6");
        reset = 1'b0;
        step();
        chk("t6_busy_after_reset", int'(bus.busy), 0);
        chk("t6_pay_two_after_reset", int'(bus.pay_two), 0);
        reset = 1'b1;
        bus.hopper_rdy = 1'b1;
        s_seq = seq.size();
        vend(1);
        wait_idle("t6");
        chk("t6_coin_count", seq.size() - s_seq, 1);
        if (seq.size() - s_seq == 1) chk("t6_coin0", seq[s_seq], 1);

        // random traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            step();
            reset          = ($urandom_range(0, 249) != 0);
            bus.d          = ($urandom_range(0, 7) == 0);
            bus.r          = 3'($urandom_range(0, 7));
            bus.hopper_rdy = ($urandom_range(0, 3) != 0);
        end
        bus.d = 1'b0;
        bus.hopper_rdy = 1'b1;
        reset = 1'b1;
        wait_idle("final");
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
